load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage sitting directly downstream of the multicycle RV32I core's EXECUTE state; consumes the effective address, rs2 value, funct3 and load/store decode.
- Drives a word-addressed memory port with byte write masks and a ready handshake.
- Returns aligned, sign- or zero-extended load data to the core's write-back path.
- Flags misaligned accesses, illegal funct3 and memory timeouts.

Parameters:
- TIMEOUT, 255: max cycles a request waits for mem_ready before aborting with error; 0 disables timeout.
- ADDR_W, 32: width of addr and mem_addr.

Ports:
- clk  in  1  system clock (core clock from clock divider)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request pulse from core
- is_load  in  1  request is a load
- is_store  in  1  request is a store
- funct3  in  3  RV32I width/sign code
- addr  in  ADDR_W  byte address (rs1+imm)
- store_data  in  32  rs2 value
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: access faulted
- load_data  out  32  extended load result, valid from done until next accepted start
- mem_addr  out  ADDR_W  word-aligned address, addr with bits [1:0] = 0
- mem_rstrb  out  1  read request, held until accepted
- mem_wmask  out  4  byte write enables, held until accepted; 0 = no write
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when mem_ready is high
- mem_ready  in  1  memory accepts/completes current request this cycle

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, err=0, load_data=0, mem_addr=0, mem_rstrb=0, mem_wmask=0, mem_wdata=0, timeout counter=0. Reset mid-request drops mem_rstrb/mem_wmask immediately, with no completion pulse.
- All outputs are registered.
- States: IDLE, REQ, FIN.
- IDLE:
  - start is accepted only in IDLE; start while busy is ignored.
  - On accept, addr, funct3, store_data and the load/store decode are latched; busy=1.
  - Fault check: is_load==is_store; load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=0.
  - Fault -> go to FIN with err=1; no memory request issued; load_data unchanged.
  - No fault -> go to REQ, driving mem_addr and mem_rstrb (load) or mem_wmask/mem_wdata (store) in the next cycle.
- REQ:
  - Request signals held stable until mem_ready=1 is sampled.
  - On mem_ready: drop the request; for a load, register extracted load_data; go to FIN, err=0.
  - Counter increments each REQ cycle without mem_ready. If TIMEOUT!=0 and the counter reaches TIMEOUT: drop the request, go to FIN, err=1, load_data unchanged.
- FIN: done=1 for exactly one cycle; busy=0 from the following cycle; return to IDLE; err holds until the next accepted start.
- Latency: start at cycle 0 -> request visible cycle 1 -> with mem_ready=1 in cycle 1, done pulses in cycle 2 (minimum 2 cycles). Each mem_ready wait cycle adds 1 cycle. Fault: done in cycle 1.
- Store mask and data:
  - SB: mask = 1<<addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: mask = addr[1] ? 1100 : 0011; wdata = {2{store_data[15:0]}}.
  - SW: mask = 1111; wdata = store_data.
- Load extraction:
  - Byte: mem_rdata[8*addr[1:0] +: 8].
  - Half: mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- mem_rdata is ignored outside REQ, and in REQ when mem_ready=0.
- mem_ready while in IDLE/FIN is ignored.
- A start coincident with done (FIN cycle) is ignored.

Test Plan:
- LB addr=0x103, mem_rdata=0x80FF_7F01, mem_ready high on first REQ cycle -> mem_addr=0x100, mem_rstrb 1 cycle, done at cycle 2, load_data=0xFFFF_FF80, err=0.
- LHU addr=0x22, mem_rdata=0x9ABC_1234, mem_ready delayed 3 cycles -> mem_rstrb held 4 cycles, load_data=0x0000_9ABC, done at cycle 5.
- SH addr=0x42, store_data=0x1111_BEEF -> mem_addr=0x40, mem_wmask=1100, mem_wdata=0xBEEF_BEEF, done after mem_ready, err=0.
- SW addr=0x13 -> no mem_rstrb/mem_wmask ever asserted, done at cycle 1 with err=1; same result for a load with funct3=011.
- TIMEOUT=4, LW with mem_ready held 0 -> request dropped after 4 REQ cycles, done with err=1, load_data retains prior value; a second start pulse during REQ is ignored.
- Assert reset during REQ of a store -> mem_wmask=0 and busy=0 immediately (before the next clk edge), no done pulse; a fresh LW after reset completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: turns a latched load/store request into a word-addressed
// memory transaction and returns aligned, extended load data with a fault flag.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       load_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rstrb_o,
  output logic [3:0]        mem_wmask_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW:0] TimeoutVal = (CntW + 1)'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StFin} state_e;

  state_e            state_q;
  logic              is_load_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q, err_q, mem_rstrb_q;
  logic [31:0]       load_data_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wmask_q;

  logic              fault;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic [31:0]       ext;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic              timeout_hit;

  // Request decode on the incoming (not yet latched) fields.
  always_comb begin
    fault = 1'b0;
    if (is_load_i == is_store_i) begin
      fault = 1'b1;
    end else if (is_load_i) begin
      fault = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      fault = !(funct3_i inside {3'b000, 3'b001, 3'b010});
    end
    if ((funct3_i[1:0] == 2'b01) && addr_i[0]) fault = 1'b1;
    if ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) fault = 1'b1;

    wmask = 4'b1111;
    wdata = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        wmask = 4'b0001 << addr_i[1:0];
        wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        wmask = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction on the latched offset and width.
  always_comb begin
    rd_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
    rd_half = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ext = {24'b0, rd_byte};
      3'b001:  ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ext = {16'b0, rd_half};
      default: ext = mem_rdata_i;
    endcase
    timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt_q} + 1'b1) == TimeoutVal);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'b0;
      mem_addr_q  <= '0;
      mem_rstrb_q <= 1'b0;
      mem_wmask_q <= 4'b0;
      mem_wdata_q <= 32'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            is_load_q <= is_load_i;
            funct3_q  <= funct3_i;
            off_q     <= addr_i[1:0];
            cnt_q     <= '0;
            if (fault) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= StReq;
              mem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
              mem_rstrb_q <= is_load_i;
              mem_wmask_q <= is_store_i ? wmask : 4'b0000;
              if (is_store_i) mem_wdata_q <= wdata;
            end
          end
        end
        StReq: begin
          if (mem_ready_i) begin
            mem_rstrb_q <= 1'b0;
            mem_wmask_q <= 4'b0000;
            if (is_load_q) load_data_q <= ext;
            state_q <= StFin;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            mem_rstrb_q <= 1'b0;
            mem_wmask_q <= 4'b0000;
            state_q <= StFin;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign load_data_o = load_data_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_rstrb_o = mem_rstrb_q;
  assign mem_wmask_o = mem_wmask_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-timeline model predicts every output each cycle,
// and directed vectors pin the model with hand-computed literals.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;
  logic        mem_ready;
  logic        busy, done, err, mem_rstrb;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .is_load_i(is_load),
    .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .store_data_i(store_data),
    .busy_o(busy), .done_o(done), .err_o(err), .load_data_o(load_data),
    .mem_addr_o(mem_addr), .mem_rstrb_o(mem_rstrb), .mem_wmask_o(mem_wmask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected outputs for the current cycle.
  bit          chk_en = 1'b0;
  bit          e_busy, e_done, e_err, e_rstrb, e_req;
  logic [3:0]  e_wmask;
  logic [31:0] e_ld, e_maddr, e_wdata;

  // Observations from the last run() call.
  int          done_k, rstrb_cyc, wmask_cyc;
  logic [3:0]  wmask_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_fault(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
    int w;
    if (ld == st) return 1'b1;
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
    if (st && f3 > 2) return 1'b1;
    w = 1 << f3[1:0];
    return (a % 32'(w)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] off, b, h;
    off = a % 4;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] off;
    off = a % 4;
    case (f3)
      3'd0:    return 4'(1 << off);
      3'd1:    return (off >= 2) ? 4'd12 : 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'd0:    return (sd & 32'hFF) * 32'h0101_0101;
      3'd1:    return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, e_busy});
      check("done", {31'b0, done}, {31'b0, e_done});
      check("mem_rstrb", {31'b0, mem_rstrb}, {31'b0, e_rstrb});
      check("mem_wmask", {28'b0, mem_wmask}, {28'b0, e_wmask});
      check("load_data", load_data, e_ld);
      if (e_done || !e_busy) check("err", {31'b0, err}, {31'b0, e_err});
      if (e_req) check("mem_addr", mem_addr, e_maddr);
      if (e_req && e_wmask != 0) check("mem_wdata", mem_wdata, e_wdata);
    end
  end

  // One transaction; dly = REQ cycles without mem_ready before it is raised.
  task automatic run(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd, input int dly,
                     input bit restart);
    bit fault, to_hit;
    int r;
    fault  = m_fault(ld, st, f3, a);
    to_hit = !fault && (TO != 0) && (dly >= int'(TO));
    r      = fault ? 0 : (to_hit ? int'(TO) : dly + 1);
    done_k = 0; rstrb_cyc = 0; wmask_cyc = 0; wmask_seen = 4'b0;
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    mem_ready = 1'b0;
    for (int k = 1; k <= r + 2; k++) begin
      @(posedge clk); #1;
      start = restart && (k == 2);
      if (start) begin
        is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0; store_data = 32'hFFFF;
      end
      mem_ready = !fault && (k == dly + 1);
      mem_rdata = mem_ready ? rd : (32'hDEAD_0000 ^ 32'(k));
      if (k <= r) begin
        e_busy = 1'b1; e_done = 1'b0; e_req = 1'b1;
        e_rstrb = ld; e_wmask = st ? m_mask(f3, a) : 4'b0; e_maddr = a & ~32'h3;
        if (st) e_wdata = m_wdata(f3, sd);
      end else if (k == r + 1) begin
        e_busy = 1'b1; e_done = 1'b1; e_req = 1'b0; e_rstrb = 1'b0; e_wmask = 4'b0;
        e_err = fault || to_hit;
        if (ld && !fault && !to_hit) e_ld = m_load(f3, a, rd);
      end else begin
        e_busy = 1'b0; e_done = 1'b0;
      end
      if (done && done_k == 0) done_k = k;
      if (mem_rstrb) rstrb_cyc++;
      if (mem_wmask != 0) begin wmask_cyc++; wmask_seen = mem_wmask; end
    end
    start = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
    addr = 32'b0; store_data = 32'b0; mem_rdata = 32'b0; mem_ready = 1'b0;
    #3;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst err", {31'b0, err}, 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_rstrb", {31'b0, mem_rstrb}, 32'd0);
    check("rst mem_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #2; reset = 1'b0;
    e_busy = 0; e_done = 0; e_err = 0; e_rstrb = 0; e_req = 0; e_wmask = 0;
    e_ld = 0; e_maddr = 0; e_wdata = 0;
    chk_en = 1'b1;

    run(1, 0, 3'b000, 32'h103, 0, 32'h80FF_7F01, 0, 0);       // LB
    check("lb data", load_data, 32'hFFFF_FF80);
    check("lb done cycle", done_k, 2);
    check("lb rstrb cycles", rstrb_cyc, 1);
    check("lb mem_addr", mem_addr, 32'h100);
    check("lb err", {31'b0, err}, 32'd0);

    run(1, 0, 3'b101, 32'h22, 0, 32'h9ABC_1234, 3, 0);        // LHU, 3 wait cycles
    check("lhu data", load_data, 32'h0000_9ABC);
    check("lhu done cycle", done_k, 5);
    check("lhu rstrb cycles", rstrb_cyc, 4);

    run(0, 1, 3'b001, 32'h42, 32'h1111_BEEF, 0, 1, 0);        // SH
    check("sh mask", {28'b0, wmask_seen}, 32'hC);
    check("sh wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh mem_addr", mem_addr, 32'h40);
    check("sh err", {31'b0, err}, 32'd0);
    check("sh keeps load_data", load_data, 32'h0000_9ABC);

    run(0, 1, 3'b010, 32'h13, 32'h5, 0, 0, 0);                // SW misaligned
    check("sw fault done cycle", done_k, 1);
    check("sw fault err", {31'b0, err}, 32'd1);
    check("sw fault no request", rstrb_cyc + wmask_cyc, 0);

    run(1, 0, 3'b011, 32'h20, 0, 0, 0, 0);                    // illegal load funct3
    check("ld011 done cycle", done_k, 1);
    check("ld011 err", {31'b0, err}, 32'd1);
    check("ld011 no request", rstrb_cyc + wmask_cyc, 0);

    run(1, 0, 3'b100, 32'h102, 0, 32'h80FF_7F01, 0, 0);       // LBU
    check("lbu data", load_data, 32'h0000_00FF);
    run(1, 0, 3'b001, 32'h2, 0, 32'h8000_1234, 2, 0);         // LH
    check("lh data", load_data, 32'hFFFF_8000);
    run(0, 1, 3'b000, 32'h3, 32'h0000_00A5, 0, 0, 0);         // SB
    check("sb mask", {28'b0, wmask_seen}, 32'h8);
    check("sb wdata", mem_wdata, 32'hA5A5_A5A5);
    run(1, 0, 3'b010, 32'h8, 0, 32'hCAFE_F00D, 0, 0);         // LW
    check("lw data", load_data, 32'hCAFE_F00D);

    run(1, 0, 3'b010, 32'h4, 0, 32'h1, 100, 1);               // LW timeout + ignored start
    check("timeout done cycle", done_k, 5);
    check("timeout err", {31'b0, err}, 32'd1);
    check("timeout rstrb cycles", rstrb_cyc, 4);
    check("timeout keeps data", load_data, 32'hCAFE_F00D);
    check("timeout no store", wmask_cyc, 0);

    run(1, 1, 3'b010, 32'h0, 0, 0, 0, 0);                     // both decodes set
    check("ldst err", {31'b0, err}, 32'd1);
    run(0, 1, 3'b100, 32'h0, 0, 0, 0, 0);                     // illegal store funct3
    check("st100 err", {31'b0, err}, 32'd1);
    run(0, 1, 3'b001, 32'h41, 0, 0, 0, 0);                    // SH odd address
    check("sh odd no request", wmask_cyc, 0);
    run(1, 0, 3'b101, 32'h3, 0, 0, 0, 0);                     // LHU odd address
    check("lhu odd done cycle", done_k, 1);

    // Reset in the middle of a store's REQ phase.
    chk_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40;
    store_data = 32'h1234_5678; mem_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("pre-reset wmask", {28'b0, mem_wmask}, 32'hF);
    reset = 1'b1; #1;
    check("reset drops wmask", {28'b0, mem_wmask}, 32'd0);
    check("reset drops busy", {31'b0, busy}, 32'd0);
    check("reset no done", {31'b0, done}, 32'd0);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    check("post-reset no done", {31'b0, done}, 32'd0);
    e_busy = 0; e_done = 0; e_err = 0; e_rstrb = 0; e_req = 0; e_wmask = 0; e_ld = 0;
    chk_en = 1'b1;
    run(1, 0, 3'b010, 32'h10, 0, 32'h1234_5678, 1, 0);        // fresh LW
    check("post-reset lw data", load_data, 32'h1234_5678);
    check("post-reset lw done cycle", done_k, 3);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
